regfile_write_arbiter: RTL and testbench

- Write-side controller for the 32x32 register file.
- Merges the single-cycle ALU result path and the multi-cycle multiply/divide unit (MDU) result path onto the file's one write port.
- Keeps a pending-destination scoreboard so the decode stage can stall on outstanding MDU results.
- Sits between the execute stage and the register file write port: wr_en, wr_dir and wr_data drive the file's write enable, write address and write data.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_write_arbiter_if.sv | 31 +++
 rtl/wb_result_fifo.sv | 49 ++++
 rtl/regfile_write_arbiter.sv | 82 ++++++++
 tb/tb_regfile_write_arbiter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and write-back entry types for the register file write side
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int REG_COUNT = 32;
  typedef logic [ADDR_W-1:0] reg_dir_t;
  typedef struct packed {
    reg_dir_t            dir;
    logic [DATA_W-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: execute-side result, issue, decode and write-port signals of the arbiter
interface regfile_write_arbiter_if;
  import regfile_pkg::*;
  logic              alu_valid;
  reg_dir_t          alu_dir;
  logic [DATA_W-1:0] alu_data;
  logic              alu_hold;
  logic              mdu_valid;
  logic              mdu_ready;
  reg_dir_t          mdu_dir;
  logic [DATA_W-1:0] mdu_data;
  logic              issue_mark;
  reg_dir_t          issue_dir;
  reg_dir_t          src_a;
  reg_dir_t          src_b;
  logic              stall;
  logic              waw_err;
  logic              wr_en;
  reg_dir_t          wr_dir;
  logic [DATA_W-1:0] wr_data;
  modport master (
    output alu_valid, alu_dir, alu_data, mdu_valid, mdu_dir, mdu_data,
           issue_mark, issue_dir, src_a, src_b,
    input  alu_hold, mdu_ready, stall, waw_err, wr_en, wr_dir, wr_data
  );
  modport slave (
    input  alu_valid, alu_dir, alu_data, mdu_valid, mdu_dir, mdu_data,
           issue_mark, issue_dir, src_a, src_b,
    output alu_hold, mdu_ready, stall, waw_err, wr_en, wr_dir, wr_data
  );
endinterface

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: power-of-two synchronous FIFO buffering MDU write-back entries
module wb_result_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_entry_t        entry_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  assign full_o  = count_q == CNT_W'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = (do_push & ~do_pop) ? count_q + CNT_W'(1) :
               (do_pop & ~do_push) ? count_q - CNT_W'(1) : count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges ALU and buffered MDU results onto the register file write port
// and tracks outstanding MDU destinations for decode stalls.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);
  wb_entry_t          head, push_entry;
  logic               full, empty, push, pop;
  logic [CNT_W-1:0]   count;
  logic               force_mdu, sel_mdu, sel_alu;
  reg_dir_t           sel_dir;
  logic [DATA_W-1:0]  sel_data;
  logic [ST_W-1:0]    starve_q, starve_d;
  logic [REG_COUNT-1:0] pending_q, pending_d, set_mask, clr_mask;
  logic               wr_en_q, wr_en_d, waw_q, waw_d;
  reg_dir_t           wr_dir_q, wr_dir_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  assign push_entry = '{dir: bus.mdu_dir, data: bus.mdu_data};
  assign push       = bus.mdu_valid & ~full;
  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  // A starved MDU head overrides a valid ALU result, which then waits upstream
  assign force_mdu     = ~empty & (starve_q == ST_W'(STARVE_MAX));
  assign sel_mdu       = force_mdu | (~bus.alu_valid & ~empty);
  assign sel_alu       = bus.alu_valid & ~force_mdu;
  assign pop           = sel_mdu;
  assign bus.mdu_ready = count < CNT_W'(FIFO_DEPTH);
  assign bus.alu_hold  = bus.alu_valid & force_mdu;
  assign bus.stall     = ((bus.src_a != '0) & pending_q[bus.src_a]) |
                         ((bus.src_b != '0) & pending_q[bus.src_b]);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_dir    = wr_dir_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.waw_err   = waw_q;
  always_comb begin
    sel_dir   = sel_mdu ? head.dir : bus.alu_dir;
    sel_data  = sel_mdu ? head.data : bus.alu_data;
    starve_d  = (empty | pop) ? '0 :
                (starve_q == ST_W'(STARVE_MAX)) ? starve_q : starve_q + ST_W'(1);
    clr_mask  = pop ? (REG_COUNT'(1) << head.dir) : '0;
    set_mask  = bus.issue_mark ? (REG_COUNT'(1) << bus.issue_dir) : '0;
    pending_d = ((pending_q & ~clr_mask) | set_mask) & ~REG_COUNT'(1);
    wr_en_d   = (sel_mdu | sel_alu) & (sel_dir != '0);
    wr_dir_d  = (sel_mdu | sel_alu) ? sel_dir : wr_dir_q;
    wr_data_d = (sel_mdu | sel_alu) ? sel_data : wr_data_q;
    waw_d     = sel_alu & (bus.alu_dir != '0) & pending_q[bus.alu_dir];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= '0;
      pending_q <= '0;
      wr_en_q   <= 1'b0;
      wr_dir_q  <= '0;
      wr_data_q <= '0;
      waw_q     <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      pending_q <= pending_d;
      wr_en_q   <= wr_en_d;
      wr_dir_q  <= wr_dir_d;
      wr_data_q <= wr_data_d;
      waw_q     <= waw_d;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random stimulus checked against a queue-based write-back model
module tb_regfile_write_arbiter;
  import regfile_pkg::*;
  logic clk, rst_n;
  int errors = 0, checks = 0;
  regfile_write_arbiter_if b ();
  regfile_write_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  initial clk = 0;
  always #5 clk = ~clk;
  wb_entry_t         mq[$];
  logic [31:0]       pend;
  int                starve;
  logic              m_en, m_waw;
  reg_dir_t          m_dir;
  logic [DATA_W-1:0] m_data;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic idle();
    b.alu_valid = 0; b.alu_dir = 0; b.alu_data = 0;
    b.mdu_valid = 0; b.mdu_dir = 0; b.mdu_data = 0;
    b.issue_mark = 0; b.issue_dir = 0; b.src_a = 0; b.src_b = 0;
  endtask
  task automatic model_clear();
    mq.delete(); pend = 0; starve = 0;
    m_en = 0; m_waw = 0; m_dir = 0; m_data = 0;
  endtask
  task automatic cycle();
    bit nonempty, ready, force_m, take_mdu, take_alu;
    wb_entry_t e;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_wr_en", b.wr_en, 0);
      chk("rst_waw", b.waw_err, 0);
      chk("rst_ready", b.mdu_ready, 1);
      chk("rst_stall", b.stall, 0);
      model_clear();
    end else begin
      nonempty = mq.size() > 0;
      ready    = mq.size() < 2;
      force_m  = nonempty && starve == 4;
      chk("mdu_ready", b.mdu_ready, ready);
      chk("alu_hold", b.alu_hold, b.alu_valid && force_m);
      chk("stall", b.stall, (b.src_a != 0 && pend[b.src_a]) || (b.src_b != 0 && pend[b.src_b]));
      chk("wr_en", b.wr_en, m_en);
      chk("waw_err", b.waw_err, m_waw);
      if (m_en) begin
        chk("wr_dir", b.wr_dir, m_dir);
        chk("wr_data", b.wr_data, m_data);
      end
      take_mdu = force_m || (!b.alu_valid && nonempty);
      take_alu = b.alu_valid && !force_m;
      m_en = 0; m_waw = 0;
      if (take_mdu) begin
        e = mq.pop_front();
        m_en = e.dir != 0; m_dir = e.dir; m_data = e.data;
        pend[e.dir] = 0;
      end else if (take_alu) begin
        m_en = b.alu_dir != 0; m_dir = b.alu_dir; m_data = b.alu_data;
        m_waw = b.alu_dir != 0 && pend[b.alu_dir];
      end
      if (b.mdu_valid && ready) mq.push_back('{dir: b.mdu_dir, data: b.mdu_data});
      starve = (!nonempty || take_mdu) ? 0 : (starve < 4 ? starve + 1 : 4);
      if (b.issue_mark && b.issue_dir != 0) pend[b.issue_dir] = 1;
      pend[0] = 0;
    end
    @(posedge clk); #1;
  endtask
  initial begin
    rst_n = 0; idle(); model_clear();
    cycle(); cycle();
    chk("reset_wr_en", b.wr_en, 0);
    chk("reset_wr_dir", b.wr_dir, 0);
    chk("reset_wr_data", b.wr_data, 0);
    chk("reset_waw", b.waw_err, 0);
    rst_n = 1;
    b.alu_valid = 1; b.alu_dir = 5; b.alu_data = 32'hDEADBEEF; #1;
    chk("alu_only_hold", b.alu_hold, 0);
    cycle();
    chk("alu_only_en", b.wr_en, 1);
    chk("alu_only_dir", b.wr_dir, 5);
    chk("alu_only_data", b.wr_data, 32'hDEADBEEF);
    b.alu_dir = 0; b.alu_data = 1;
    cycle();
    chk("alu_r0_en", b.wr_en, 0);
    idle(); b.mdu_valid = 1; b.mdu_dir = 0; b.mdu_data = 32'hAA;
    cycle();
    b.mdu_valid = 0;
    cycle();
    chk("mdu_r0_en", b.wr_en, 0);
    b.issue_mark = 1; b.issue_dir = 9;
    cycle();
    b.issue_mark = 0; b.src_a = 9; #1;
    chk("sb_stall_set", b.stall, 1);
    b.mdu_valid = 1; b.mdu_dir = 9; b.mdu_data = 32'h12345678;
    cycle();
    b.mdu_valid = 0; #1;
    chk("sb_stall_before_pop", b.stall, 1);
    cycle();
    chk("sb_mdu_en", b.wr_en, 1);
    chk("sb_mdu_dir", b.wr_dir, 9);
    chk("sb_mdu_data", b.wr_data, 32'h12345678);
    chk("sb_stall_clear", b.stall, 0);
    idle();
    b.alu_valid = 1; b.alu_dir = 10; b.alu_data = 32'hA0;
    b.mdu_valid = 1; b.mdu_dir = 3; b.mdu_data = 32'h100;
    cycle();
    b.mdu_dir = 4; b.mdu_data = 32'h200;
    cycle();
    b.mdu_dir = 6; b.mdu_data = 32'h300; #1;
    chk("full_ready", b.mdu_ready, 0);
    for (int i = 0; i < 3; i++) begin
      b.alu_data = 32'hB0 + i; #1;
      chk("starve_no_hold", b.alu_hold, 0);
      cycle();
    end
    b.alu_data = 32'hC0; #1;
    chk("starve_hold", b.alu_hold, 1);
    cycle();
    chk("starve_mdu_dir", b.wr_dir, 3);
    chk("starve_mdu_data", b.wr_data, 32'h100);
    chk("starve_hold_released", b.alu_hold, 0);
    cycle();
    chk("held_alu_dir", b.wr_dir, 10);
    chk("held_alu_data", b.wr_data, 32'hC0);
    b.mdu_valid = 0; b.alu_valid = 0;
    cycle();
    chk("drain_dir4", b.wr_dir, 4);
    cycle();
    chk("drain_dir6", b.wr_dir, 6);
    chk("drain_data6", b.wr_data, 32'h300);
    idle(); b.issue_mark = 1; b.issue_dir = 7;
    cycle();
    b.issue_mark = 0; b.alu_valid = 1; b.alu_dir = 7; b.alu_data = 32'h77;
    cycle();
    chk("waw_pulse", b.waw_err, 1);
    chk("waw_wr_en", b.wr_en, 1);
    b.alu_valid = 0; b.src_a = 7; #1;
    chk("waw_pending_kept", b.stall, 1);
    cycle();
    chk("waw_one_cycle", b.waw_err, 0);
    for (int n = 0; n < 3000; n++) begin
      b.alu_valid  = $urandom_range(0, 1);
      b.alu_dir    = reg_dir_t'($urandom_range(0, 7));
      b.alu_data   = $urandom;
      b.mdu_valid  = $urandom_range(0, 9) < 4;
      b.mdu_dir    = reg_dir_t'($urandom_range(0, 7));
      b.mdu_data   = $urandom;
      b.issue_mark = $urandom_range(0, 9) < 3;
      b.issue_dir  = reg_dir_t'($urandom_range(0, 7));
      b.src_a      = reg_dir_t'($urandom_range(0, 7));
      b.src_b      = reg_dir_t'($urandom_range(0, 7));
      if (n == 1500) begin
        #2 rst_n = 0; #1;
        chk("async_wr_en", b.wr_en, 0);
        chk("async_wr_dir", b.wr_dir, 0);
        chk("async_wr_data", b.wr_data, 0);
        chk("async_waw", b.waw_err, 0);
        chk("async_stall", b.stall, 0);
        cycle();
        rst_n = 1; #1;
        chk("release_ready", b.mdu_ready, 1);
      end
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
